main_control_fsm: RTL
=====================

MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL provide: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: opcode  input  7  instr[6:0] from instruction register; sampled in DECODE and MEMADR.
REQ-004 SHALL provide: mem_ready  input  1  memory completes current read/write this cycle.
REQ-005 SHALL provide: pc_write  output  1  unconditional PC load.
REQ-006 SHALL provide: pc_write_cond  output  1  PC load qualified by ALU zero (beq).
REQ-007 SHALL provide: pc_source  output  1  0 = ALU result, 1 = ALUOut register.
REQ-008 SHALL provide: i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 SHALL provide: mem_read, mem_write, ir_write  output  1 each  memory strobes / IR load.
REQ-010 SHALL provide: mem_to_reg, reg_write  output  1 each  writeback select (1 = MDR) / register-file write.
REQ-011 SHALL provide: alu_src_a  output  1  0 = PC, 1 = rs1 register.
REQ-012 SHALL provide: alu_src_b  output  2  00 = rs2, 01 = constant 4, 10 = immediate.
REQ-013 SHALL provide: ALUOp  output  2  to ALU control unit: 00 add, 01 subtract, 10 use funct.
REQ-014 SHALL provide: illegal_op  output  1  sticky unsupported-opcode flag.
REQ-015 SHALL provide: state  output  4  current state encoding, for debug.

Function
REQ-016 SHALL implement states, encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ILLEGAL=9; codes 10-15 SHALL go to FETCH next cycle with all strobes 0.
REQ-017 SHALL decode opcodes: 0000011 lw, 0100011 sw, 0110011 R-type, 1100011 beq; any other opcode is illegal.
REQ-018 SHALL, in FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUOp=00, pc_source=0; ir_write=pc_write=mem_ready (Mealy); stay while mem_ready=0, else go to DECODE.
REQ-019 SHALL, in DECODE: alu_src_a=0, alu_src_b=10, ALUOp=00 (branch target into ALUOut); next is MEMADR for lw/sw, EXEC for R-type, BRANCH for beq, ILLEGAL otherwise.
REQ-020 SHALL, in MEMADR: alu_src_a=1, alu_src_b=10, ALUOp=00; next is MEMRD for lw, MEMWR for sw.
REQ-021 SHALL, in MEMRD: mem_read=1, i_or_d=1; hold while mem_ready=0, else go to MEMWB.
REQ-022 SHALL, in MEMWB: reg_write=1, mem_to_reg=1; next is FETCH.
REQ-023 SHALL, in MEMWR: mem_write=1, i_or_d=1; hold while mem_ready=0, else go to FETCH.
REQ-024 SHALL, in EXEC: alu_src_a=1, alu_src_b=00, ALUOp=10; next is ALUWB.
REQ-025 SHALL, in ALUWB: reg_write=1, mem_to_reg=0; next is FETCH.
REQ-026 SHALL, in BRANCH: alu_src_a=1, alu_src_b=00, ALUOp=01, pc_write_cond=1, pc_source=1; next is FETCH.
REQ-027 SHALL, in ILLEGAL: all strobes 0, illegal_op=1; remain there until reset.
REQ-028 SHALL drive every output not listed for a state to 0; all outputs other than ir_write/pc_write SHALL be a function of state only.
REQ-029 SHALL never assert mem_read and mem_write together, nor assert reg_write outside MEMWB/ALUWB.
REQ-030 SHALL give instruction latency (mem_ready=1 throughout): R-type 4 cycles, lw 5, sw 4, beq 3.

Reset
REQ-031 SHALL, while rst_n=0, force state=FETCH and illegal_op=0 immediately, independent of clk.
REQ-032 SHALL, during reset, hold all write strobes (pc_write, pc_write_cond, mem_write, ir_write, reg_write) at 0 regardless of mem_ready.
REQ-033 SHALL, when reset is asserted mid-instruction, abandon that instruction; the first edge after release evaluates FETCH.

Verification
REQ-034 R-type 0110011, mem_ready=1 -> state 0,1,6,7,0; ALUOp 00,00,10,00; reg_write=1 only in state 7.
REQ-035 lw, mem_ready=0 for 3 cycles in MEMRD -> state 3 held 4 cycles with mem_read=1, i_or_d=1; then state 4 with reg_write=1, mem_to_reg=1; total 8 cycles.
REQ-036 beq 1100011 -> state 8 with ALUOp=01, pc_write_cond=1, pc_source=1, pc_write=0; then FETCH.
REQ-037 opcode 1111111 -> state 9, illegal_op=1 held for 20 cycles with all strobes 0; rst_n pulse -> state 0, illegal_op=0.
REQ-038 rst_n low mid-MEMWR with mem_ready=0 -> mem_write falls with no clk edge; state=0 after release.
REQ-039 FETCH with mem_ready=0 for 2 cycles -> mem_read=1, ir_write=pc_write=0; both 1 in the mem_ready=1 cycle.

Source files
------------

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle control unit for lw/sw/R-type/beq.
// Moore control word per state; ir_write/pc_write follow mem_ready in FETCH.
module main_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] ALUOp,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ILLEGAL = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   fetch_done;
    logic   is_lw;
    logic   is_sw;
    logic   is_r;
    logic   is_beq;

    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_r   = (opcode == OP_R);
    assign is_beq = (opcode == OP_BEQ);

    // State register and sticky illegal flag; reset clears both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == ILLEGAL)
                illegal_q <= 1'b1;
        end
    end

    // Next-state and per-state control word; unused codes fall to FETCH.
    always_comb begin
        state_d       = FETCH;
        fetch_done    = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        ALUOp         = 2'b00;
        unique case (state_q)
            FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = 2'b01;
                fetch_done = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_b = 2'b10;
                unique case (1'b1)
                    is_lw, is_sw: state_d = MEMADR;
                    is_r:         state_d = EXEC;
                    is_beq:       state_d = BRANCH;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                unique case (1'b1)
                    is_lw:   state_d = MEMRD;
                    is_sw:   state_d = MEMWR;
                    default: state_d = ILLEGAL;
                endcase
            end
            MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                ALUOp     = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                ALUOp         = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 1'b1;
                state_d       = FETCH;
            end
            ILLEGAL: begin
                state_d = ILLEGAL;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // FETCH sits in reset, so gate the Mealy strobes with rst_n.
    assign ir_write   = fetch_done & rst_n;
    assign pc_write   = fetch_done & rst_n;
    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule
